dmem_sram_bridge: RTL and testbench
===================================

// Module: dmem_sram_bridge
// PURPOSE
//  Sits directly downstream of the memory stage, on the memory_dram side. Turns each M-stage load/store
//  into one transaction on an SRAM-like data bus (req/addr_ok/data_ok). Stalls the pipeline until the
//  access completes, then holds load data stable while M stays stalled by other hazards.
//  Owns the only outstanding-transaction state on the data side, including drain after flush.
// PARAMETERS
//  ADDR_W  32  byte address width on both sides
//  DATA_W  32  data width; byte strobes are DATA_W/8 wide
// PORTS
//  clk           in   1         single clock; all state updates on posedge
//  resetn        in   1         asynchronous, active-low reset
//  m_valid       in   1         M stage holds a live memory instruction (load or store)
//  m_wen         in   1         1=store, 0=load
//  m_addr        in   ADDR_W    byte address from M stage
//  m_size        in   2         0=byte 1=half 2=word (3 illegal, treated as word)
//  m_wdata       in   DATA_W    store data, already lane-aligned by M stage
//  m_advance     in   1         M instr leaves stage this edge (=~stallM & ~flushM)
//  m_flush       in   1         M instr cancelled (exception/flushM)
//  m_rd          out  DATA_W    load data to M stage (memory_dram.rd)
//  m_stall       out  1         request stallM to hazard unit
//  data_req      out  1         bus request
//  data_wr       out  1         bus write
//  data_size     out  2         bus size = m_size
//  data_addr     out  ADDR_W    bus address = m_addr
//  data_wdata    out  DATA_W    bus write data = m_wdata
//  data_addr_ok  in   1         request accepted this cycle
//  data_data_ok  in   1         response (rdata/write-ack) this cycle
//  data_rdata    in   DATA_W    load data, valid with data_data_ok
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, rdata_q=0. Outputs: data_req=0, m_stall=0, m_rd=0.
//   The other data_* outputs are don't-care while data_req=0.
//  States: IDLE, WAIT (accepted, awaiting data_ok), DONE (result held), DRAIN (flushed, awaiting data_ok).
//  IDLE: data_req = m_valid & ~m_flush (combinational). Bus fields are driven from M inputs.
//   addr_ok=1 -> WAIT. addr_ok=0 -> stay, req held with stable fields.
//  WAIT: data_req=0. On data_ok, rdata_q<=data_rdata.
//   data_ok & m_advance -> IDLE. data_ok & ~m_advance -> DONE. ~data_ok & m_flush -> DRAIN.
//  DONE: data_req=0. m_advance or m_flush -> IDLE.
//   Never re-issues, so a store executes exactly once per instruction.
//  DRAIN: data_req=0. data_ok -> IDLE; its data is discarded.
//   While in DRAIN, m_stall=1 if m_valid (new instr must wait).
//  m_stall = m_valid & ~m_flush & ~(state==DONE) & ~(state==WAIT & data_ok); also 1 in DRAIN as above.
//  m_rd = (state==WAIT & data_ok) ? data_rdata : rdata_q. Bypass gives zero extra cycle on return.
//  Latency: addr_ok in the req cycle and data_ok on the next cycle -> 1 stall cycle.
//   The instruction advances on the data_ok edge.
//  At most one outstanding transaction. data_ok is never expected in IDLE/DONE; assert on it in sim.
//  m_flush in IDLE before addr_ok: request withdrawn, no transaction.
//   m_flush in the same cycle as addr_ok: req is already gated by ~m_flush, so nothing is issued.
//  m_flush and data_ok in the same WAIT cycle: -> IDLE, data dropped.
//  resetn low mid-transaction: state is discarded immediately. The bus is reset together with the core.
// STRUCTURE
//  mips.svh gains the shared items below. dmem_sram_bridge uses dbridge_state_t.
//   - typedef enum logic[1:0] {MSIZE_B, MSIZE_H, MSIZE_W} msize_t
//   - typedef enum logic[1:0] {DB_IDLE, DB_WAIT, DB_DONE, DB_DRAIN} dbridge_state_t
//   - typedef struct sram_req_t {req, wr, size, addr, wdata}
//  The memory_dram interface is extended with this bridge's M-side signals.
//  No sub-module. Single FSM plus one data register; the stall/rd logic is one always_comb.
// TESTING
//  1 Load, addr_ok same cycle, data_ok next cycle with rdata=32'hDEADBEEF
//    -> m_stall=1 for exactly 1 cycle, m_rd=DEADBEEF on the data_ok cycle.
//  2 Store word addr 0x80001000 with addr_ok delayed 3 cycles
//    -> data_req held 4 cycles with stable addr/wdata, exactly one accepted write.
//  3 Load completes while m_advance=0 for 5 cycles (external stall)
//    -> state DONE, m_rd stays DEADBEEF, no second data_req.
//  4 m_flush in WAIT, data_ok 2 cycles later, a new load in M meanwhile
//    -> DRAIN, old data dropped, new req only after the drain data_ok.
//  5 resetn pulsed low during WAIT
//    -> data_req=0, m_stall=0, m_rd=0 immediately (asynchronous); IDLE after release.
//  6 Back-to-back loads, 0-wait bus
//    -> one stall cycle each, no lost or duplicated transactions (scoreboard).

Source files
------------

// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types for the data-side SRAM bridge: access sizes, bridge FSM states
// and the bundled bus request.
package dmem_sram_bridge_pkg;

    localparam int unsigned SramAddrW = 32;
    localparam int unsigned SramDataW = 32;

    typedef enum logic [1:0] {MSIZE_B, MSIZE_H, MSIZE_W} msize_t;

    typedef enum logic [1:0] {DB_IDLE, DB_WAIT, DB_DONE, DB_DRAIN} dbridge_state_t;

    typedef struct packed {
        logic                 req;
        logic                 wr;
        logic [1:0]           size;
        logic [SramAddrW-1:0] addr;
        logic [SramDataW-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/dmem_sram_bridge.sv
// Bridges one M-stage load/store to a single SRAM-like bus transaction, stalling M until
// the response arrives and holding load data while M is stalled elsewhere.
module dmem_sram_bridge
    import dmem_sram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = SramAddrW,
    parameter int unsigned DATA_W = SramDataW
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m_valid,
    input  logic              m_wen,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [1:0]        m_size,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic              m_advance,
    input  logic              m_flush,
    output logic [DATA_W-1:0] m_rd,
    output logic              m_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    dbridge_state_t    stateQ;
    logic [DATA_W-1:0] rdataQ;
    sram_req_t         busReq;
    logic              waitHit;

    always_comb begin
        waitHit      = (stateQ == DB_WAIT) & data_data_ok;
        // Gating with resetn keeps req/stall low the instant reset asserts.
        busReq.req   = resetn & (stateQ == DB_IDLE) & m_valid & ~m_flush;
        busReq.wr    = m_wen;
        busReq.size  = m_size;
        busReq.addr  = m_addr;
        busReq.wdata = m_wdata;
        if (stateQ == DB_DRAIN) begin
            m_stall = resetn & m_valid;
        end else begin
            m_stall = resetn & m_valid & ~m_flush & (stateQ != DB_DONE) & ~waitHit;
        end
        m_rd = waitHit ? data_rdata : rdataQ;
    end

    assign data_req   = busReq.req;
    assign data_wr    = busReq.wr;
    assign data_size  = busReq.size;
    assign data_addr  = busReq.addr;
    assign data_wdata = busReq.wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ <= DB_IDLE;
            rdataQ <= '0;
        end else begin
            unique case (stateQ)
                DB_IDLE: begin
                    if (busReq.req && data_addr_ok) stateQ <= DB_WAIT;
                end
                DB_WAIT: begin
                    if (data_data_ok) begin
                        rdataQ <= data_rdata;
                        stateQ <= (m_advance || m_flush) ? DB_IDLE : DB_DONE;
                    end else if (m_flush) begin
                        stateQ <= DB_DRAIN;
                    end
                end
                // Result is held until M moves on; no re-issue, so stores run once.
                DB_DONE: begin
                    if (m_advance || m_flush) stateQ <= DB_IDLE;
                end
                DB_DRAIN: begin
                    if (data_data_ok) stateQ <= DB_IDLE;
                end
                default: stateQ <= DB_IDLE;
            endcase
        end
    end

    noOrphanResp: assert property (@(posedge clk) disable iff (!resetn)
        !(data_data_ok && (stateQ == DB_IDLE || stateQ == DB_DONE)));

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: a transaction-level model checked every cycle plus
// hand-computed expectations per scenario.
module tb_dmem_sram_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mValid, mWen, mFlush, extStall;
    logic [31:0] mAddr, mWdata;
    logic [1:0]  mSize;
    logic        mAdvance;
    logic [31:0] mRd;
    logic        mStall;
    logic        dataReq, dataWr, dataAddrOk, dataDataOk;
    logic [1:0]  dataSize;
    logic [31:0] dataAddr, dataWdata, dataRdata;

    always #5 clk = ~clk;

    // Pipeline advance as the hazard unit would form it.
    assign mAdvance = ~mStall & ~extStall & ~mFlush;

    dmem_sram_bridge dut (
        .clk         (clk),
        .resetn      (resetn),
        .m_valid     (mValid),
        .m_wen       (mWen),
        .m_addr      (mAddr),
        .m_size      (mSize),
        .m_wdata     (mWdata),
        .m_advance   (mAdvance),
        .m_flush     (mFlush),
        .m_rd        (mRd),
        .m_stall     (mStall),
        .data_req    (dataReq),
        .data_wr     (dataWr),
        .data_size   (dataSize),
        .data_addr   (dataAddr),
        .data_wdata  (dataWdata),
        .data_addr_ok(dataAddrOk),
        .data_data_ok(dataDataOk),
        .data_rdata  (dataRdata)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    endtask

    // Transaction-level model: an accepted-but-unanswered access, whether its instruction
    // has been cancelled, and a returned result still owed to a stalled instruction.
    logic        pending = 1'b0, orphan = 1'b0, haveResult = 1'b0;
    logic [31:0] result = '0;
    int          dutAcc = 0, modelAcc = 0;
    logic [31:0] accAddr[$];

    function automatic logic expReqF();
        return resetn && !pending && !haveResult && mValid && !mFlush;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending    <= 1'b0;
            orphan     <= 1'b0;
            haveResult <= 1'b0;
        end else begin
            if (dataReq && dataAddrOk) begin
                dutAcc <= dutAcc + 1;
                accAddr.push_back(dataAddr);
            end
            if (expReqF() && dataAddrOk) begin
                pending  <= 1'b1;
                modelAcc <= modelAcc + 1;
            end else if (pending) begin
                if (dataDataOk) begin
                    pending <= 1'b0;
                    orphan  <= 1'b0;
                    if (!orphan && !mFlush && !mAdvance) begin
                        haveResult <= 1'b1;
                        result     <= dataRdata;
                    end
                end else if (mFlush) begin
                    orphan <= 1'b1;
                end
            end else if (haveResult && (mAdvance || mFlush)) begin
                haveResult <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic expStall;
        if (!resetn) begin
            chk("m_req_rst", dataReq, 0);
            chk("m_stall_rst", mStall, 0);
            chk("m_rd_rst", mRd, 0);
        end else begin
            if (orphan) expStall = mValid;
            else expStall = mValid && !mFlush && !haveResult && !(pending && dataDataOk);
            chk("m_req", dataReq, expReqF());
            chk("m_stall", mStall, expStall);
            if (expReqF()) begin
                chk("m_wr", dataWr, mWen);
                chk("m_size", dataSize, mSize);
                chk("m_addr", dataAddr, mAddr);
                chk("m_wdata", dataWdata, mWdata);
            end
            if (pending && !orphan && dataDataOk && !mFlush) chk("m_rd_bypass", mRd, dataRdata);
            if (haveResult) chk("m_rd_held", mRd, result);
        end
    end

    logic        sReq, sStall, sWr;
    logic [31:0] sRd, sAddr, sWdata;

    // Drive one cycle of inputs, then snapshot outputs away from the clock edge.
    task automatic cyc(input logic v, input logic w, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] wd, input logic fl,
                       input logic ext, input logic aok, input logic dok, input logic [31:0] rd);
        mValid     = v;
        mWen       = w;
        mAddr      = a;
        mSize      = sz;
        mWdata     = wd;
        mFlush     = fl;
        extStall   = ext;
        dataAddrOk = aok;
        dataDataOk = dok;
        dataRdata  = dok ? rd : 32'h5A5A_5A5A;
        @(negedge clk);
        #1;
        sReq   = dataReq;
        sStall = mStall;
        sWr    = dataWr;
        sRd    = mRd;
        sAddr  = dataAddr;
        sWdata = dataWdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 2'd2, 32'h0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        int stallCnt, reqCnt, acc0, q0;
        resetn = 1'b0;
        mValid = 1'b1; mWen = 1'b0; mAddr = 32'h10; mSize = 2'd2; mWdata = '0;
        mFlush = 1'b0; extStall = 1'b0; dataAddrOk = 1'b0; dataDataOk = 1'b0;
        dataRdata = '0;
        @(posedge clk);
        #1;
        chk("reset_req", dataReq, 0);
        chk("reset_stall", mStall, 0);
        chk("reset_rd", mRd, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle();

        // 1: load, addr_ok immediately, data_ok next cycle
        stallCnt = 0;
        cyc(1, 0, 32'h100, 2'd2, 32'h0, 0, 0, 1, 0, 32'h0);
        chk("t1_req", sReq, 1);
        stallCnt += int'(sStall);
        cyc(1, 0, 32'h100, 2'd2, 32'h0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("t1_rd", sRd, 32'hDEAD_BEEF);
        stallCnt += int'(sStall);
        idle();
        chk("t1_stall_cycles", stallCnt, 1);

        // 2: store word, addr_ok three cycles late
        acc0 = dutAcc;
        reqCnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 32'h8000_1000, 2'd2, 32'h1234_5678, 0, 0, (i == 3), 0, 32'h0);
            reqCnt += int'(sReq);
            chk("t2_addr", sAddr, 32'h8000_1000);
            chk("t2_wdata", sWdata, 32'h1234_5678);
        end
        cyc(1, 1, 32'h8000_1000, 2'd2, 32'h1234_5678, 0, 0, 0, 1, 32'h0);
        chk("t2_done_stall", sStall, 0);
        idle();
        chk("t2_req_cycles", reqCnt, 4);
        chk("t2_accepts", dutAcc - acc0, 1);

        // 3: load completes under an external stall of 5 cycles
        acc0 = dutAcc;
        cyc(1, 0, 32'h200, 2'd2, 32'h0, 0, 1, 1, 0, 32'h0);
        cyc(1, 0, 32'h200, 2'd2, 32'h0, 0, 1, 0, 1, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 32'h200, 2'd2, 32'h0, 0, 1, 1, 0, 32'h0);
            chk("t3_hold_rd", sRd, 32'hDEAD_BEEF);
            chk("t3_hold_req", sReq, 0);
            chk("t3_hold_stall", sStall, 0);
        end
        cyc(1, 0, 32'h200, 2'd2, 32'h0, 0, 0, 0, 0, 32'h0);
        chk("t3_release_rd", sRd, 32'hDEAD_BEEF);
        idle();
        chk("t3_accepts", dutAcc - acc0, 1);

        // 4: flush while waiting, data returns two cycles later, next load waits
        acc0 = dutAcc;
        cyc(1, 0, 32'h300, 2'd2, 32'h0, 0, 0, 1, 0, 32'h0);
        cyc(1, 0, 32'h300, 2'd2, 32'h0, 1, 0, 0, 0, 32'h0);
        cyc(1, 0, 32'h304, 2'd2, 32'h0, 0, 0, 1, 0, 32'h0);
        chk("t4_drain_req", sReq, 0);
        chk("t4_drain_stall", sStall, 1);
        cyc(1, 0, 32'h304, 2'd2, 32'h0, 0, 0, 1, 1, 32'h0BAD_BAD0);
        chk("t4_dok_req", sReq, 0);
        chk("t4_dok_stall", sStall, 1);
        cyc(1, 0, 32'h304, 2'd2, 32'h0, 0, 0, 1, 0, 32'h0);
        chk("t4_new_req", sReq, 1);
        chk("t4_new_addr", sAddr, 32'h304);
        cyc(1, 0, 32'h304, 2'd2, 32'h0, 0, 0, 0, 1, 32'h1111_2222);
        chk("t4_new_rd", sRd, 32'h1111_2222);
        chk("t4_new_stall", sStall, 0);
        idle();
        chk("t4_accepts", dutAcc - acc0, 2);

        // 7: flush with addr_ok in IDLE, then flush together with data_ok in WAIT
        acc0 = dutAcc;
        cyc(1, 0, 32'h600, 2'd2, 32'h0, 1, 0, 1, 0, 32'h0);
        chk("t7_withdraw_req", sReq, 0);
        cyc(1, 0, 32'h604, 2'd2, 32'h0, 0, 0, 1, 0, 32'h0);
        cyc(1, 0, 32'h604, 2'd2, 32'h0, 1, 0, 0, 1, 32'h0000_0077);
        chk("t7_flushok_stall", sStall, 0);
        cyc(1, 0, 32'h608, 2'd3, 32'h0, 0, 0, 1, 0, 32'h0);
        chk("t7_reissue_req", sReq, 1);
        cyc(1, 0, 32'h608, 2'd3, 32'h0, 0, 0, 0, 1, 32'h0000_0088);
        chk("t7_rd", sRd, 32'h0000_0088);
        idle();
        chk("t7_accepts", dutAcc - acc0, 2);

        // 5: asynchronous reset in WAIT
        cyc(1, 0, 32'h400, 2'd2, 32'h0, 0, 0, 1, 0, 32'h0);
        mValid = 1'b1; mFlush = 1'b0; extStall = 1'b0; dataAddrOk = 1'b0; dataDataOk = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("t5_async_req", dataReq, 0);
        chk("t5_async_stall", mStall, 0);
        chk("t5_async_rd", mRd, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc(1, 0, 32'h404, 2'd2, 32'h0, 0, 0, 0, 0, 32'h0);
        chk("t5_idle_req", sReq, 1);
        chk("t5_idle_rd", sRd, 32'h0);
        cyc(1, 0, 32'h404, 2'd2, 32'h0, 0, 0, 1, 0, 32'h0);
        cyc(1, 0, 32'h404, 2'd2, 32'h0, 0, 0, 0, 1, 32'hCAFE_F00D);
        chk("t5_rd", sRd, 32'hCAFE_F00D);

        // 6: back-to-back loads on a zero-wait bus
        acc0 = dutAcc;
        q0 = accAddr.size();
        stallCnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 32'h500 + 32'(4 * i), 2'd2, 32'h0, 0, 0, 1, 0, 32'h0);
            stallCnt += int'(sStall);
            cyc(1, 0, 32'h500 + 32'(4 * i), 2'd2, 32'h0, 0, 0, 0, 1, 32'hA000_0000 + 32'(i));
            stallCnt += int'(sStall);
            chk("t6_rd", sRd, 32'hA000_0000 + 32'(i));
        end
        idle();
        chk("t6_stall_cycles", stallCnt, 4);
        chk("t6_accepts", dutAcc - acc0, 4);
        if (accAddr.size() == q0 + 4) begin
            for (int i = 0; i < 4; i++) chk("t6_order", accAddr[q0 + i], 32'h500 + 32'(4 * i));
        end
        chk("model_vs_dut_accepts", dutAcc, modelAcc);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
